delayed_pulse_gen: RTL and testbench



---
 rtl/dpg_pkg.sv | 35 +++
 rtl/delayed_pulse_gen_if.sv | 27 ++
 rtl/dpg_channel.sv | 115 +++++++++++
 rtl/delayed_pulse_gen.sv | 45 ++++
 tb/tb_delayed_pulse_gen.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dpg_pkg : shared types, edge-select encodings and defaults for the |
// |           delayed pulse generator.           Rev 1.0               |
// +--------------------------------------------------------------------+
package dpg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_PULSE = 2'd2
   } dpg_state_t;

   localparam logic [1:0] c_edge_rise = 2'b00;
   localparam logic [1:0] c_edge_fall = 2'b01;
   localparam logic [1:0] c_edge_both = 2'b10;
   localparam logic [1:0] c_edge_off  = 2'b11;

   localparam int unsigned c_def_delay   = 300_000;
   localparam int unsigned c_def_pulse_w = 4;

   function automatic logic edge_hit(input logic [1:0] sel, input logic cur, input logic prev);
      logic hit;
      hit = 1'b0;
      case (sel)
         c_edge_rise: hit = cur & ~prev;
         c_edge_fall: hit = ~cur & prev;
         c_edge_both: hit = cur ^ prev;
         default:     hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage
`default_nettype wire

// File: rtl/delayed_pulse_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | delayed_pulse_gen_if : trigger/config/status bundle for the        |
// |                        delayed pulse generator.   Rev 1.0          |
// +--------------------------------------------------------------------+
interface delayed_pulse_gen_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 32
);
   logic [NUM_CH-1:0]       trig_in;
   logic [2*NUM_CH-1:0]     edge_sel;
   logic [CNT_W*NUM_CH-1:0] delay_cfg;
   logic [NUM_CH-1:0]       pulse_out;
   logic [NUM_CH-1:0]       busy;
   logic [NUM_CH-1:0]       overrun;

   modport master (
      output trig_in, edge_sel, delay_cfg,
      input  pulse_out, busy, overrun
   );

   modport slave (
      input  trig_in, edge_sel, delay_cfg,
      output pulse_out, busy, overrun
   );
endinterface
`default_nettype wire

// File: rtl/dpg_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dpg_channel : one synchronised, edge-triggered delayed one-shot.   |
// | DPG_RETRIGGER_EN : edge during DELAY restarts the delay. Rev 1.0   |
// +--------------------------------------------------------------------+
module dpg_channel
   import dpg_pkg::*;
#(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned PULSE_W   = c_def_pulse_w,
   parameter int unsigned DEF_DELAY = c_def_delay
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_trig,
   input  logic [1:0]       i_edge_sel,
   input  logic [CNT_W-1:0] i_delay_cfg,
   output logic             o_pulse,
   output logic             o_busy,
   output logic             o_overrun
);

   localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_pulse_last = CNT_W'(PULSE_W - 1);

   logic             r_s1, r_s2, r_s3;
   dpg_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_dly, w_dly_nxt;
   logic             r_ovr_evt, w_ovr_evt;
   logic             r_pulse, r_busy, r_overrun;
   logic             w_edge;

   assign w_edge = edge_hit(i_edge_sel, r_s2, r_s3);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dly_nxt   = r_dly;
      w_ovr_evt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_edge) begin
               w_dly_nxt   = i_delay_cfg;
               w_cnt_nxt   = '0;
               w_state_nxt = (i_delay_cfg == '0) ? ST_PULSE : ST_DELAY;
            end
         end
         ST_DELAY: begin
            // D is never zero here, so D-1 cannot underflow
            if (r_cnt == (r_dly - c_one)) begin
               w_state_nxt = ST_PULSE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + c_one;
            end
`ifdef DPG_RETRIGGER_EN
            if (w_edge) begin
               w_dly_nxt   = i_delay_cfg;
               w_cnt_nxt   = '0;
               w_state_nxt = (i_delay_cfg == '0) ? ST_PULSE : ST_DELAY;
            end
`else
            w_ovr_evt = w_edge;
`endif
         end
         ST_PULSE: begin
            w_ovr_evt = w_edge;
            if (r_cnt == c_pulse_last) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + c_one;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_s3      <= 1'b0;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_dly     <= CNT_W'(DEF_DELAY);
         r_ovr_evt <= 1'b0;
         r_pulse   <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_s1      <= i_trig;
         r_s2      <= r_s1;
         r_s3      <= r_s2;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_dly     <= w_dly_nxt;
         r_ovr_evt <= w_ovr_evt;
         // Outputs trail the state by one cycle, overrun aligned with them
         r_pulse   <= (r_state == ST_PULSE);
         r_busy    <= (r_state != ST_IDLE);
         r_overrun <= r_ovr_evt;
      end
   end

   assign o_pulse   = r_pulse;
   assign o_busy    = r_busy;
   assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/delayed_pulse_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | delayed_pulse_gen : NUM_CH independent delayed one-shot channels.  |
// | DPG_RETRIGGER_EN : edge during DELAY restarts the delay. Rev 1.0   |
// +--------------------------------------------------------------------+
module delayed_pulse_gen
   import dpg_pkg::*;
#(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned PULSE_W   = c_def_pulse_w,
   parameter int unsigned DEF_DELAY = c_def_delay
) (
   input  logic         clk,
   input  logic         rst_n,
   delayed_pulse_gen_if.slave bus
);

   logic [NUM_CH-1:0] w_pulse;
   logic [NUM_CH-1:0] w_busy;
   logic [NUM_CH-1:0] w_overrun;

   for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
      dpg_channel #(
         .CNT_W     (CNT_W),
         .PULSE_W   (PULSE_W),
         .DEF_DELAY (DEF_DELAY)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_trig      (bus.trig_in[g]),
         .i_edge_sel  (bus.edge_sel[2*g +: 2]),
         .i_delay_cfg (bus.delay_cfg[g*CNT_W +: CNT_W]),
         .o_pulse     (w_pulse[g]),
         .o_busy      (w_busy[g]),
         .o_overrun   (w_overrun[g])
      );
   end

   assign bus.pulse_out = w_pulse;
   assign bus.busy      = w_busy;
   assign bus.overrun   = w_overrun;

endmodule
`default_nettype wire

// File: tb/tb_delayed_pulse_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_delayed_pulse_gen : directed self-checking bench.   Rev 1.0     |
// +--------------------------------------------------------------------+
module tb_delayed_pulse_gen;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   delayed_pulse_gen_if #(.NUM_CH(4), .CNT_W(32)) bus_if ();

   delayed_pulse_gen #(
      .NUM_CH(4), .CNT_W(32), .PULSE_W(4), .DEF_DELAY(300_000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic settle();
      bus_if.edge_sel = 8'hFF;
      bus_if.trig_in  = 4'h0;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n            = 1'b0;
      bus_if.trig_in   = 4'h0;
      bus_if.edge_sel  = 8'hFF;
      bus_if.delay_cfg = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus_if.pulse_out !== 4'h0) begin
         n_errors++; $display("FAIL reset_pulse got=%b exp=0000", bus_if.pulse_out);
      end
      n_checks++;
      if (bus_if.busy !== 4'h0) begin
         n_errors++; $display("FAIL reset_busy got=%b exp=0000", bus_if.busy);
      end
      n_checks++;
      if (bus_if.overrun !== 4'h0) begin
         n_errors++; $display("FAIL reset_overrun got=%b exp=0000", bus_if.overrun);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_rising();
      logic ep, eb;
      settle();
      bus_if.edge_sel[1:0]   = 2'b00;
      bus_if.delay_cfg[31:0] = 32'd10;
      bus_if.trig_in[0]      = 1'b1;
      for (int j = 0; j <= 20; j++) begin
         @(posedge clk); #1;
         ep = (j >= 13 && j <= 16);
         eb = (j >= 3 && j <= 16);
         n_checks++;
         if (bus_if.pulse_out[0] !== ep) begin
            n_errors++; $display("FAIL rising_pulse rel=%0d got=%b exp=%b", j, bus_if.pulse_out[0], ep);
         end
         n_checks++;
         if (bus_if.busy[0] !== eb) begin
            n_errors++; $display("FAIL rising_busy rel=%0d got=%b exp=%b", j, bus_if.busy[0], eb);
         end
         n_checks++;
         if (bus_if.overrun[0] !== 1'b0) begin
            n_errors++; $display("FAIL rising_overrun rel=%0d got=%b exp=0", j, bus_if.overrun[0]);
         end
      end
   endtask

   task automatic test_falling_d0();
      logic ep;
      settle();
      bus_if.trig_in[0] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      bus_if.edge_sel[1:0]   = 2'b01;
      bus_if.delay_cfg[31:0] = 32'd0;
      bus_if.trig_in[0]      = 1'b0;
      for (int j = 0; j <= 10; j++) begin
         @(posedge clk); #1;
         ep = (j >= 3 && j <= 6);
         n_checks++;
         if (bus_if.pulse_out[0] !== ep) begin
            n_errors++; $display("FAIL falling_d0_pulse rel=%0d got=%b exp=%b", j, bus_if.pulse_out[0], ep);
         end
         n_checks++;
         if (bus_if.busy[0] !== ep) begin
            n_errors++; $display("FAIL falling_d0_busy rel=%0d got=%b exp=%b", j, bus_if.busy[0], ep);
         end
      end
   endtask

   task automatic test_second_edge();
      logic ep, eb, eo;
      settle();
      bus_if.edge_sel[1:0]   = 2'b00;
      bus_if.delay_cfg[31:0] = 32'd20;
      bus_if.trig_in[0]      = 1'b1;
      for (int j = 0; j <= 35; j++) begin
         @(posedge clk); #1;
`ifdef DPG_RETRIGGER_EN
         ep = (j >= 28 && j <= 31);
         eb = (j >= 3 && j <= 31);
         eo = 1'b0;
`else
         ep = (j >= 23 && j <= 26);
         eb = (j >= 3 && j <= 26);
         eo = (j == 8);
`endif
         n_checks++;
         if (bus_if.pulse_out[0] !== ep) begin
            n_errors++; $display("FAIL second_edge_pulse rel=%0d got=%b exp=%b", j, bus_if.pulse_out[0], ep);
         end
         n_checks++;
         if (bus_if.busy[0] !== eb) begin
            n_errors++; $display("FAIL second_edge_busy rel=%0d got=%b exp=%b", j, bus_if.busy[0], eb);
         end
         n_checks++;
         if (bus_if.overrun[0] !== eo) begin
            n_errors++; $display("FAIL second_edge_overrun rel=%0d got=%b exp=%b", j, bus_if.overrun[0], eo);
         end
         bus_if.trig_in[0] = !((j + 1) >= 2 && (j + 1) < 5);
      end
   endtask

   task automatic test_pulse_overrun();
      logic ep, eo;
      settle();
      bus_if.edge_sel[1:0]   = 2'b00;
      bus_if.delay_cfg[31:0] = 32'd0;
      bus_if.trig_in[0]      = 1'b1;
      for (int j = 0; j <= 14; j++) begin
         @(posedge clk); #1;
         ep = (j >= 3 && j <= 6);
         eo = (j == 6);
         n_checks++;
         if (bus_if.pulse_out[0] !== ep) begin
            n_errors++; $display("FAIL pulse_ovr_pulse rel=%0d got=%b exp=%b", j, bus_if.pulse_out[0], ep);
         end
         n_checks++;
         if (bus_if.busy[0] !== ep) begin
            n_errors++; $display("FAIL pulse_ovr_busy rel=%0d got=%b exp=%b", j, bus_if.busy[0], ep);
         end
         n_checks++;
         if (bus_if.overrun[0] !== eo) begin
            n_errors++; $display("FAIL pulse_ovr_overrun rel=%0d got=%b exp=%b", j, bus_if.overrun[0], eo);
         end
         bus_if.trig_in[0] = !((j + 1) >= 1 && (j + 1) < 3);
      end
   endtask

   task automatic test_edge_both();
      logic ep, eb;
      settle();
      bus_if.edge_sel[1:0]   = 2'b10;
      bus_if.delay_cfg[31:0] = 32'd8;
      bus_if.trig_in[0]      = 1'b1;
      for (int j = 0; j <= 50; j++) begin
         @(posedge clk); #1;
         ep = (j >= 11 && j <= 14) || (j >= 41 && j <= 44);
         eb = (j >= 3 && j <= 14) || (j >= 33 && j <= 44);
         n_checks++;
         if (bus_if.pulse_out[0] !== ep) begin
            n_errors++; $display("FAIL both_pulse rel=%0d got=%b exp=%b", j, bus_if.pulse_out[0], ep);
         end
         n_checks++;
         if (bus_if.busy[0] !== eb) begin
            n_errors++; $display("FAIL both_busy rel=%0d got=%b exp=%b", j, bus_if.busy[0], eb);
         end
         bus_if.trig_in[0] = ((j + 1) < 30);
      end
   endtask

   task automatic test_edge_disabled();
      settle();
      bus_if.delay_cfg[31:0] = 32'd8;
      bus_if.trig_in[0]      = 1'b1;
      for (int j = 0; j <= 50; j++) begin
         @(posedge clk); #1;
         n_checks++;
         if (bus_if.pulse_out[0] !== 1'b0 || bus_if.busy[0] !== 1'b0) begin
            n_errors++; $display("FAIL disabled_quiet rel=%0d got=%b%b exp=00", j, bus_if.pulse_out[0], bus_if.busy[0]);
         end
         bus_if.trig_in[0] = ((j + 1) < 30);
      end
   endtask

   task automatic test_reset_mid();
      logic ep, eb;
      settle();
      bus_if.edge_sel[1:0]   = 2'b00;
      bus_if.delay_cfg[31:0] = 32'd20;
      bus_if.trig_in[0]      = 1'b1;
      for (int j = 0; j <= 45; j++) begin
         @(posedge clk); #1;
         ep = (j >= 34 && j <= 37);
         eb = (j >= 3 && j <= 9) || (j >= 14 && j <= 37);
         n_checks++;
         if (bus_if.pulse_out[0] !== ep) begin
            n_errors++; $display("FAIL reset_mid_pulse rel=%0d got=%b exp=%b", j, bus_if.pulse_out[0], ep);
         end
         n_checks++;
         if (bus_if.busy[0] !== eb) begin
            n_errors++; $display("FAIL reset_mid_busy rel=%0d got=%b exp=%b", j, bus_if.busy[0], eb);
         end
         if (j == 9)  rst_n = 1'b0;
         if (j == 10) rst_n = 1'b1;
      end
   endtask

   task automatic test_all_channels();
      logic [3:0] ep, eb;
      settle();
      bus_if.edge_sel  = 8'h00;
      bus_if.delay_cfg = {32'd8, 32'd7, 32'd6, 32'd5};
      bus_if.trig_in   = 4'hF;
      for (int j = 0; j <= 20; j++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++) begin
            ep[i] = (j >= 8 + i && j <= 11 + i);
            eb[i] = (j >= 3 && j <= 11 + i);
         end
         n_checks++;
         if (bus_if.pulse_out !== ep) begin
            n_errors++; $display("FAIL all_ch_pulse rel=%0d got=%b exp=%b", j, bus_if.pulse_out, ep);
         end
         n_checks++;
         if (bus_if.busy !== eb) begin
            n_errors++; $display("FAIL all_ch_busy rel=%0d got=%b exp=%b", j, bus_if.busy, eb);
         end
         n_checks++;
         if (bus_if.overrun !== 4'h0) begin
            n_errors++; $display("FAIL all_ch_overrun rel=%0d got=%b exp=0000", j, bus_if.overrun);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_rising();
      test_falling_d0();
      test_second_edge();
      test_pulse_overrun();
      test_edge_both();
      test_edge_disabled();
      test_reset_mid();
      test_all_channels();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
